// File: rtl/mem_rmw_pkg.sv
// ---------------------------------------------------------------------------
// mem_rmw_pkg
// Shared definitions for the read-modify-write initiator:
//   state_e       - controller states
//   WSTRB_FULL    - byte strobes for a full-word write
//   WSTRB_NONE    - byte strobes for a read
//   ADDR_DEFAULT  - default word address of the counter location
// ---------------------------------------------------------------------------
package mem_rmw_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT_WR = 3'd1,
        RD      = 3'd2,
        WR      = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [3:0]  WSTRB_FULL   = 4'hF;
    localparam logic [3:0]  WSTRB_NONE   = 4'h0;
    localparam logic [31:0] ADDR_DEFAULT = 32'h0000_03FC;

endpackage

// File: rtl/mem_req_watchdog.sv
// ---------------------------------------------------------------------------
// mem_req_watchdog
// Counts the cycles a bus request has been outstanding and flags expiry when
// the request has been valid for TIMEOUT cycles without mem_ready.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   req_start in   high in the cycle before a new request is raised
//   active    in   request currently valid (mem_valid)
//   ready     in   responder completion strobe
//   expired   out  request has reached its cycle limit this cycle
// ---------------------------------------------------------------------------
module mem_req_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic req_start,
    input  logic active,
    input  logic ready,
    output logic expired
);

    // The count equals the number of completed cycles the request has
    // already spent waiting, so the last allowed cycle is TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (req_start) begin
            cnt_d = '0;
        end else if (active && !ready && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the final cycle wins over expiry.
    assign expired = active && !ready && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_rmw_initiator.sv
// ---------------------------------------------------------------------------
// mem_rmw_initiator
// Bus master on a native picorv32-style memory interface. On start it clears
// a counter word at ADDR, then repeats NUM_ITERS times: read the word, check
// it against the last value written, write back value+1. A mismatch or a
// request that waits TIMEOUT cycles for mem_ready ends the run with error.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   start                   single-cycle pulse, accepted in IDLE/DONE only
//   mem_valid, mem_instr    request valid / instruction flag (always 0)
//   mem_ready, mem_rdata    responder completion strobe and read data
//   mem_addr, mem_wdata,
//   mem_wstrb               request address, write data, byte strobes
//   busy, done, error       run status
//   iter_count              completed read-increment-write iterations
// ---------------------------------------------------------------------------
module mem_rmw_initiator
    import mem_rmw_pkg::*;
#(
    parameter logic [31:0] ADDR      = ADDR_DEFAULT,
    parameter int          NUM_ITERS = 16,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] iter_count
);

    localparam logic [15:0] ITERS_TARGET = 16'(NUM_ITERS);

    state_e      state_q,     state_d;
    state_e      after_gap_q, after_gap_d;   // request issued when GAP ends
    logic        valid_q,     valid_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [3:0]  wstrb_q,     wstrb_d;
    logic [31:0] expected_q,  expected_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        error_q,     error_d;
    logic [15:0] iter_q,      iter_d;

    logic handshake;
    logic expired;
    logic req_start;

    assign handshake = valid_q && mem_ready;
    assign req_start = valid_d && !valid_q;

    mem_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .req_start (req_start),
        .active    (valid_q),
        .ready     (mem_ready),
        .expired   (expired)
    );

    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        expected_d  = expected_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        iter_d      = iter_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = INIT_WR;
                    valid_d = 1'b1;
                    addr_d  = ADDR;
                    wdata_d = '0;
                    wstrb_d = WSTRB_FULL;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    iter_d  = '0;
                end
            end
            INIT_WR: begin
                if (handshake) begin
                    // Bus fields for the next request are loaded while
                    // mem_valid is low, so they never move under a request.
                    state_d     = GAP;
                    after_gap_d = RD;
                    valid_d     = 1'b0;
                    expected_d  = '0;
                    wdata_d     = '0;
                    wstrb_d     = WSTRB_NONE;
                end
            end
            RD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (mem_rdata != expected_q) begin
                        state_d = DONE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = GAP;
                        after_gap_d = WR;
                        wdata_d     = mem_rdata + 32'd1;
                        wstrb_d     = WSTRB_FULL;
                    end
                end
            end
            WR: begin
                if (handshake) begin
                    valid_d    = 1'b0;
                    iter_d     = iter_q + 16'd1;
                    expected_d = wdata_q;
                    if ((iter_q + 16'd1) == ITERS_TARGET) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = GAP;
                        after_gap_d = RD;
                        wdata_d     = '0;
                        wstrb_d     = WSTRB_NONE;
                    end
                end
            end
            GAP: begin
                state_d = after_gap_q;
                valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // expired is only raised for an outstanding request without ready,
        // so it can never collide with a completion above.
        if (expired) begin
            state_d = DONE;
            valid_d = 1'b0;
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            after_gap_q <= IDLE;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            expected_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            expected_q  <= expected_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            iter_q      <= iter_d;
        end
    end

    assign mem_valid  = valid_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign iter_count = iter_q;

endmodule
